// File: rtl/cu_pkg.sv
// Shared types and constants for the ThetaCore control-unit pipeline sequencer.
package cu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALT   = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        HC_NONE     = 3'd0,
        HC_ECALL    = 3'd1,
        HC_EBREAK   = 3'd2,
        HC_ALU      = 3'd3,
        HC_ILLEGAL  = 3'd4,
        HC_PC_RANGE = 3'd5,
        HC_MISALIGN = 3'd6
    } halt_cause_t;

    localparam int unsigned PC_STEP = 4;

    // Wide enough for any practical pipeline depth; port indices are zero-extended into it.
    typedef logic [7:0] stage_idx_t;

endpackage

// File: rtl/cu_stage_slot.sv
// One pipeline stage register: valid bit plus PC, with hold/flush/bubble/load controls.
module cu_stage_slot
    import cu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            flush,
    input  logic            bubble,
    input  logic            load,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    output logic            valid,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
        end else if (!hold) begin
            // flush drops a wrong-path instruction; bubble inserts an empty slot behind a stall
            if (flush) begin
                valid <= 1'b0;
            end else if (bubble) begin
                valid <= 1'b0;
                pc    <= '0;
            end else if (load) begin
                valid <= in_valid;
                pc    <= in_pc;
            end
        end
    end

endmodule

// File: rtl/cu_pipe_sequencer.sv
// N-stage, P-phase pipeline sequencer: fetch PC, per-stage valid/PC, stall bubbles,
// redirect flushes and sticky error halt for the ThetaCore control unit.
module cu_pipe_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned     NUM_STAGES = 5,
    parameter int unsigned     PHASES     = 4,
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] PC_LIMIT   = XLEN'(512)
) (
    input  logic                          soc_clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_STAGES-1:0]         stall_req,
    input  logic                          redirect_valid,
    input  logic [$clog2(NUM_STAGES)-1:0] redirect_stage,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          err_ecall,
    input  logic                          err_ebreak,
    input  logic                          err_alu,
    input  logic                          err_illegal,
    output logic [$clog2(PHASES)-1:0]     phase,
    output logic [NUM_STAGES-1:0]         stage_valid,
    output logic [NUM_STAGES-1:0]         stage_advance,
    output logic [XLEN-1:0]               fetch_pc,
    output logic                          retire_valid,
    output logic [XLEN-1:0]               retire_pc,
    output logic [1:0]                    state,
    output logic                          halted,
    output logic [2:0]                    halt_cause
);

    localparam int unsigned     TOP        = NUM_STAGES - 1;
    localparam int unsigned     PW         = $clog2(PHASES);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(PHASES - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

    seq_state_t      state_q;
    halt_cause_t     cause_q;
    halt_cause_t     cause_d;
    logic [PW-1:0]   phase_q;
    logic [XLEN-1:0] fetch_q;

    logic            rd_pend;
    stage_idx_t      rd_stage;
    logic [XLEN-1:0] rd_pc;

    logic            eff_valid;
    stage_idx_t      eff_stage;
    logic [XLEN-1:0] eff_pc;

    logic                  active, adv, do_adv, halt_now;
    logic                  misalign, pc_range, top_fill;
    logic                  stall_any;
    stage_idx_t            stall_top;
    logic [NUM_STAGES-1:0] stall_m, hold, bubble, flush;
    logic [NUM_STAGES-1:0] slot_valid, in_valid;
    logic [XLEN-1:0]       slot_pc [NUM_STAGES];
    logic [XLEN-1:0]       in_pc   [NUM_STAGES];

    always_comb begin
        active = (state_q == ST_WARMUP) || (state_q == ST_RUN);
        adv    = active && (phase_q == LAST_PHASE);

        // A request arriving this cycle competes with the latched one; the older stage wins.
        eff_valid = rd_pend;
        eff_stage = rd_stage;
        eff_pc    = rd_pc;
        if (redirect_valid && (!rd_pend || (stage_idx_t'(redirect_stage) > rd_stage))) begin
            eff_valid = 1'b1;
            eff_stage = stage_idx_t'(redirect_stage);
            eff_pc    = redirect_pc;
        end

        stall_m   = stall_req;
        stall_any = 1'b0;
        stall_top = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (eff_valid && (stage_idx_t'(i) <= eff_stage)) stall_m[i] = 1'b0;
            if (stall_m[i]) begin
                stall_any = 1'b1;
                stall_top = stage_idx_t'(i);
            end
        end

        // Flushed stages below the redirect point never hold, even under a surviving stall above them.
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            hold[i]   = stall_any && (stage_idx_t'(i) <= stall_top);
            bubble[i] = stall_any && (stage_idx_t'(i) == stall_top + stage_idx_t'(1));
            flush[i]  = 1'b0;
            if (eff_valid && (stage_idx_t'(i) <= eff_stage)) begin
                hold[i]  = 1'b0;
                flush[i] = (i != 0);
            end
        end

        in_valid[0] = 1'b1;
        in_pc[0]    = eff_valid ? eff_pc : fetch_q;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            in_valid[i] = slot_valid[i-1];
            in_pc[i]    = slot_pc[i-1];
        end

        misalign = adv && eff_valid && (eff_pc[1:0] != 2'b00);
        pc_range = adv && !eff_valid && !hold[0] && (fetch_q >= PC_LIMIT);

        if (err_illegal)     cause_d = HC_ILLEGAL;
        else if (misalign)   cause_d = HC_MISALIGN;
        else if (pc_range)   cause_d = HC_PC_RANGE;
        else if (err_alu)    cause_d = HC_ALU;
        else if (err_ecall)  cause_d = HC_ECALL;
        else if (err_ebreak) cause_d = HC_EBREAK;
        else                 cause_d = HC_NONE;

        halt_now = active && (cause_d != HC_NONE);
        do_adv   = adv && !halt_now;

        stage_advance = do_adv ? ~hold : '0;
        top_fill      = do_adv && !hold[TOP] && !bubble[TOP] && !flush[TOP] && in_valid[TOP];
        retire_valid  = (state_q == ST_RUN) && do_adv && slot_valid[TOP] && !hold[TOP];
    end

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cause_q  <= HC_NONE;
            phase_q  <= '0;
            fetch_q  <= RESET_PC;
            rd_pend  <= 1'b0;
            rd_stage <= '0;
            rd_pc    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_WARMUP;
                end
                ST_WARMUP, ST_RUN: begin
                    if (halt_now) begin
                        state_q <= ST_HALT;
                        cause_q <= cause_d;
                    end else begin
                        phase_q <= adv ? '0 : phase_q + PW'(1);
                        if ((state_q == ST_WARMUP) && top_fill) state_q <= ST_RUN;
                        if (adv) begin
                            rd_pend <= 1'b0;
                            if (eff_valid)     fetch_q <= eff_pc + STEP;
                            else if (!hold[0]) fetch_q <= fetch_q + STEP;
                        end else begin
                            rd_pend  <= eff_valid;
                            rd_stage <= eff_stage;
                            rd_pc    <= eff_pc;
                        end
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
        cu_stage_slot #(
            .XLEN(XLEN)
        ) u_slot (
            .clk      (soc_clk),
            .rst_n    (reset),
            .hold     (!do_adv || hold[g]),
            .flush    (do_adv && flush[g]),
            .bubble   (do_adv && bubble[g]),
            .load     (do_adv),
            .in_valid (in_valid[g]),
            .in_pc    (in_pc[g]),
            .valid    (slot_valid[g]),
            .pc       (slot_pc[g])
        );
    end

    assign phase       = phase_q;
    assign stage_valid = slot_valid;
    assign fetch_pc    = fetch_q;
    assign retire_pc   = slot_pc[TOP];
    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign halt_cause  = cause_q;

endmodule

// File: tb/tb_cu_pipe_sequencer.sv
// Directed, table-driven bench for cu_pipe_sequencer at default parameters.
module tb_cu_pipe_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  stall_req;
    logic        redirect_valid;
    logic [2:0]  redirect_stage;
    logic [31:0] redirect_pc;
    logic        err_ecall, err_ebreak, err_alu, err_illegal;
    logic [1:0]  phase;
    logic [4:0]  stage_valid;
    logic [4:0]  stage_advance;
    logic [31:0] fetch_pc;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [1:0]  state;
    logic        halted;
    logic [2:0]  halt_cause;

    cu_pipe_sequencer #(
        .NUM_STAGES(5),
        .PHASES    (4),
        .XLEN      (32),
        .RESET_PC  (32'd0),
        .PC_LIMIT  (32'd512)
    ) dut (
        .soc_clk        (clk),
        .reset          (reset),
        .start          (start),
        .stall_req      (stall_req),
        .redirect_valid (redirect_valid),
        .redirect_stage (redirect_stage),
        .redirect_pc    (redirect_pc),
        .err_ecall      (err_ecall),
        .err_ebreak     (err_ebreak),
        .err_alu        (err_alu),
        .err_illegal    (err_illegal),
        .phase          (phase),
        .stage_valid    (stage_valid),
        .stage_advance  (stage_advance),
        .fetch_pc       (fetch_pc),
        .retire_valid   (retire_valid),
        .retire_pc      (retire_pc),
        .state          (state),
        .halted         (halted),
        .halt_cause     (halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [4:0] valid;
        logic [1:0] st;
        logic [1:0] ph;
        logic [31:0] fpc;
        logic [4:0] adv;
    } bu_vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] err;   // {illegal, alu, ecall, ebreak}
        logic       mis;
        logic [2:0] cause;
    } err_vec_t;

    bu_vec_t  bu [8];
    err_vec_t ev [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task clear_inputs;
        start          = 1'b0;
        stall_req      = '0;
        redirect_valid = 1'b0;
        redirect_stage = '0;
        redirect_pc    = '0;
        err_ecall      = 1'b0;
        err_ebreak     = 1'b0;
        err_alu        = 1'b0;
        err_illegal    = 1'b0;
    endtask

    task do_reset;
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task start_pulse;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    task run_until(input int target);
        while (cyc < target) tick();
    endtask

    task run_bringup;
        start_pulse();
        for (int k = 0; k < 8; k++) begin
            run_until(bu[k].cyc);
            check($sformatf("bu_valid@%0d", bu[k].cyc), stage_valid, bu[k].valid);
            check($sformatf("bu_state@%0d", bu[k].cyc), state, bu[k].st);
            check($sformatf("bu_phase@%0d", bu[k].cyc), phase, bu[k].ph);
            check($sformatf("bu_fetch@%0d", bu[k].cyc), fetch_pc, bu[k].fpc);
            check($sformatf("bu_adv@%0d", bu[k].cyc), stage_advance, bu[k].adv);
        end
        run_until(22);
        check("bu_retire_v@22", retire_valid, 0);
        run_until(23);
        check("bu_retire_v@23", retire_valid, 1);
        check("bu_retire_pc@23", retire_pc, 0);
    endtask

    initial begin
        bu[0] = '{0,  5'b00000, 2'd1, 2'd0, 32'd0,  5'b00000};
        bu[1] = '{3,  5'b00000, 2'd1, 2'd3, 32'd0,  5'b11111};
        bu[2] = '{4,  5'b00001, 2'd1, 2'd0, 32'd4,  5'b00000};
        bu[3] = '{8,  5'b00011, 2'd1, 2'd0, 32'd8,  5'b00000};
        bu[4] = '{12, 5'b00111, 2'd1, 2'd0, 32'd12, 5'b00000};
        bu[5] = '{16, 5'b01111, 2'd1, 2'd0, 32'd16, 5'b00000};
        bu[6] = '{19, 5'b01111, 2'd1, 2'd3, 32'd16, 5'b11111};
        bu[7] = '{20, 5'b11111, 2'd2, 2'd0, 32'd20, 5'b00000};

        ev[0] = '{1, 4'b0110, 1'b0, 3'd3};
        ev[1] = '{1, 4'b0011, 1'b0, 3'd1};
        ev[2] = '{2, 4'b0001, 1'b0, 3'd2};
        ev[3] = '{1, 4'b1100, 1'b0, 3'd4};
        ev[4] = '{3, 4'b0100, 1'b1, 3'd6};
        ev[5] = '{3, 4'b1000, 1'b1, 3'd4};
        ev[6] = '{3, 4'b0000, 1'b1, 3'd6};
        ev[7] = '{2, 4'b1111, 1'b0, 3'd4};

        clear_inputs();
        reset = 1'b0;
        #3;
        check("rst_state", state, 0);
        check("rst_phase", phase, 0);
        check("rst_valid", stage_valid, 0);
        check("rst_fetch", fetch_pc, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_adv", stage_advance, 0);
        do_reset();

        // Errors while idle are ignored
        err_illegal = 1'b1;
        tick();
        err_illegal = 1'b0;
        check("idle_err_state", state, 0);
        check("idle_err_cause", halt_cause, 0);

        run_bringup();

        // Stall on stage 2 for the window ending at cycle 28
        run_until(24);
        stall_req = 5'b00100;
        run_until(27);
        check("stall_adv", stage_advance, 5'b11000);
        check("stall_retire_v", retire_valid, 1);
        check("stall_retire_pc", retire_pc, 4);
        tick();
        stall_req = '0;
        check("stall_valid", stage_valid, 5'b10111);
        check("stall_fetch", fetch_pc, 24);
        run_until(31);
        check("post_stall_retire_pc", retire_pc, 8);
        run_until(32);
        check("bubble_valid", stage_valid, 5'b01111);
        check("bubble_fetch", fetch_pc, 28);

        // Redirect from stage 2 wins over a later one from stage 1
        run_until(33);
        redirect_valid = 1'b1; redirect_stage = 3'd2; redirect_pc = 32'h100;
        tick();
        redirect_stage = 3'd1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_adv", stage_advance, 5'b11111);
        check("redir_retire_v", retire_valid, 0);
        tick();
        check("redir_valid", stage_valid, 5'b11001);
        check("redir_fetch", fetch_pc, 32'h104);
        run_until(39);
        check("redir_retire_pc@39", retire_pc, 12);
        run_until(47);
        check("redir_retire_v@47", retire_valid, 0);
        run_until(52);
        check("redir_fetch@52", fetch_pc, 32'h114);
        run_until(55);
        check("redir_retire_v@55", retire_valid, 1);
        check("redir_retire_pc@55", retire_pc, 32'h100);

        // Asynchronous reset at phase 2 with a redirect pending
        run_until(57);
        redirect_valid = 1'b1; redirect_stage = 3'd2; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        check("pre_reset_phase", phase, 2);
        reset = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_phase", phase, 0);
        check("mid_rst_valid", stage_valid, 0);
        check("mid_rst_fetch", fetch_pc, 0);
        check("mid_rst_halted", halted, 0);
        tick();
        reset = 1'b1;
        tick();
        run_bringup();

        // Halt cause priority table
        for (int k = 0; k < 8; k++) begin
            do_reset();
            start_pulse();
            run_until(ev[k].cyc);
            {err_illegal, err_alu, err_ecall, err_ebreak} = ev[k].err;
            if (ev[k].mis) begin
                redirect_valid = 1'b1; redirect_stage = 3'd1; redirect_pc = 32'h102;
            end
            tick();
            clear_inputs();
            check($sformatf("err%0d_halted", k), halted, 1);
            check($sformatf("err%0d_cause", k), halt_cause, ev[k].cause);
            check($sformatf("err%0d_phase", k), phase, ev[k].cyc);
            check($sformatf("err%0d_valid", k), stage_valid, 0);
            err_illegal = 1'b1;
            tick();
            err_illegal = 1'b0;
            repeat (3) tick();
            check($sformatf("err%0d_sticky", k), halt_cause, ev[k].cause);
            check($sformatf("err%0d_frozen", k), phase, ev[k].cyc);
            check($sformatf("err%0d_noadv", k), stage_advance, 0);
        end

        // Free run into the fetch limit
        do_reset();
        start_pulse();
        for (int n = 0; n < 700 && !halted; n++) tick();
        check("lim_halted", halted, 1);
        check("lim_cycle", cyc, 516);
        check("lim_cause", halt_cause, 5);
        check("lim_fetch", fetch_pc, 512);
        check("lim_valid", stage_valid, 5'b11111);
        check("lim_retire_pc", retire_pc, 492);
        check("lim_phase", phase, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
